// File: rtl/riscv_pkg.sv
// Core-wide RISC-V constants shared by the pipeline and its debug blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/trace_pkg.sv
// Types for the commit trace buffer: one stored retirement record.
// Latency: n/a (types only).
// Backpressure: n/a. The ts field exists only when COMMIT_TRACE_TIMESTAMP_EN is defined.
package trace_pkg;
  localparam int TS_W = 32;

  typedef struct packed {
    logic [riscv_pkg::XLEN-1:0] pc;
    logic [riscv_pkg::XLEN-1:0] instr;
    logic [4:0]                 rd;
    logic [riscv_pkg::XLEN-1:0] rd_data;
    logic                       stall;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]            ts;
`endif
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);
endpackage

// File: rtl/trace_ring_mem.sv
// Register-array storage for trace entries: two write ports, one async read port.
// Latency: write visible on rdata_o the cycle after the write edge; read is combinational.
// Backpressure: none; the owner guarantees the two write addresses differ.
// Ports: clk_i; we0_i/waddr0_i/wdata0_i, we1_i/waddr1_i/wdata1_i; raddr_i -> rdata_o.
module trace_ring_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we0_i,
  input  logic [AW-1:0]      waddr0_i,
  input  logic [ENTRY_W-1:0] wdata0_i,
  input  logic               we1_i,
  input  logic [AW-1:0]      waddr1_i,
  input  logic [ENTRY_W-1:0] wdata1_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Contents are never reset; the owner's count gates every read.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem[waddr0_i] <= wdata0_i;
    if (we1_i) mem[waddr1_i] <= wdata1_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into a circular trace buffer drained by valid/ready.
// Latency: entry written at edge N is visible on out_* after edge N (no empty bypass).
// Backpressure: none toward the core; when full, stop mode drops newest, wrap mode
//   overwrites oldest; losses are counted in drop_cnt_o and flagged in overflow_o.
// Ports: clk_i/rstn_i; ret_* retire lanes (lane 0 older); trace_en_i, filter_stall_i,
//   wrap_mode_i, flush_i controls; out_* FWFT head with out_valid_o/out_ready_i;
//   count_o, drop_cnt_o, overflow_o status. COMMIT_TRACE_TIMESTAMP_EN adds out_ts_o.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int RET_W = 1,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [RET_W-1:0]           ret_valid_i,
  input  logic [RET_W*XLEN-1:0]      ret_pc_i,
  input  logic [RET_W*XLEN-1:0]      ret_instr_i,
  input  logic [RET_W*5-1:0]         ret_rd_i,
  input  logic [RET_W*XLEN-1:0]      ret_rd_data_i,
  input  logic [RET_W-1:0]           ret_stall_i,
  input  logic                       trace_en_i,
  input  logic                       filter_stall_i,
  input  logic                       wrap_mode_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [XLEN-1:0]            out_instr_o,
  output logic [4:0]                 out_rd_o,
  output logic [XLEN-1:0]            out_rd_data_o,
  output logic                       out_stall_o,
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]            out_ts_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_X = DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  logic [RET_W-1:0] elig;
  logic [1:0]       n_elig, n_acc, n_drop, n_disc;
  logic             pop;
  logic [CW:0]      free, occ;
  logic [CNT_W:0]   drop_sum;

  trace_entry_t     lane_ent [RET_W];
  trace_entry_t     wr_ent0, wr_ent1, rd_ent;
  logic [ENTRY_W-1:0] rd_raw;
  logic             we0, we1;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      ts_q <= '0;
    else if (flush_i) ts_q <= '0;
    else              ts_q <= ts_q + 1'b1;
  end
`endif

  assign elig = ret_valid_i & {RET_W{trace_en_i}} & ~({RET_W{filter_stall_i}} & ret_stall_i);
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    for (int k = 0; k < RET_W; k++) begin
      lane_ent[k]         = '0;
      lane_ent[k].pc      = ret_pc_i[k*XLEN +: XLEN];
      lane_ent[k].instr   = ret_instr_i[k*XLEN +: XLEN];
      lane_ent[k].rd      = ret_rd_i[k*5 +: 5];
      lane_ent[k].rd_data = ret_rd_data_i[k*XLEN +: XLEN];
      lane_ent[k].stall   = ret_stall_i[k];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      lane_ent[k].ts      = ts_q;
`endif
    end
  end

  // Admission policy. occ is the would-be occupancy if every eligible lane
  // landed; a popped head is consumed, so it never counts as a discard.
  always_comb begin
    n_elig = '0;
    for (int k = 0; k < RET_W; k++) n_elig = n_elig + {1'b0, elig[k]};
    free      = DEPTH_X - {1'b0, count} + {{CW{1'b0}}, pop};
    occ       = {1'b0, count} - {{CW{1'b0}}, pop} + {{(CW-1){1'b0}}, n_elig};
    n_acc     = n_elig;
    n_drop    = '0;
    n_disc    = '0;
    count_nxt = occ[CW-1:0];
    if (wrap_mode_i) begin
      // At most two lanes arrive, so the excess is 1 or 2.
      if (occ > DEPTH_X) begin
        n_disc    = (occ == DEPTH_X + 2) ? 2'd2 : 2'd1;
        n_drop    = n_disc;
        count_nxt = DEPTH_C;
      end
    end else if ({{(CW-1){1'b0}}, n_elig} > free) begin
      // free is 0 or 1 here; the oldest lanes are the ones kept.
      n_acc     = free[1:0];
      n_drop    = n_elig - free[1:0];
      count_nxt = DEPTH_C;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(n_acc);
      rd_ptr   <= rd_ptr + AW'(pop) + AW'(n_disc);
      count    <= count_nxt;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      overflow <= overflow | (n_drop != 2'd0);
    end
  end

  // Eligible lanes are packed: the oldest eligible lane always takes wr_ptr.
  generate
    if (RET_W == 2) begin : g_two_lane
      assign wr_ent0 = elig[0] ? lane_ent[0] : lane_ent[1];
      assign wr_ent1 = lane_ent[1];
    end else begin : g_one_lane
      assign wr_ent0 = lane_ent[0];
      assign wr_ent1 = lane_ent[0];
    end
  endgenerate

  assign we0 = !flush_i && (n_acc != 2'd0);
  assign we1 = !flush_i && (n_acc == 2'd2);

  trace_ring_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i    (clk_i),
    .we0_i    (we0),
    .waddr0_i (wr_ptr),
    .wdata0_i (wr_ent0),
    .we1_i    (we1),
    .waddr1_i (wr_ptr + AW'(1)),
    .wdata1_i (wr_ent1),
    .raddr_i  (rd_ptr),
    .rdata_o  (rd_raw)
  );

  assign rd_ent = trace_entry_t'(rd_raw);

  assign out_valid_o   = (count != '0);
  assign out_pc_o      = out_valid_o ? rd_ent.pc    : '0;
  assign out_instr_o   = out_valid_o ? rd_ent.instr : '0;
  assign out_rd_o      = out_valid_o ? rd_ent.rd    : '0;
  assign out_rd_data_o = (out_valid_o && rd_ent.rd != 5'd0) ? rd_ent.rd_data : '0;
  assign out_stall_o   = out_valid_o ? rd_ent.stall : 1'b0;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  assign out_ts_o      = out_valid_o ? rd_ent.ts : '0;
`endif
  assign count_o       = count;
  assign drop_cnt_o    = drop_cnt;
  assign overflow_o    = overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (two retire lanes, 16 entries).
// Latency: inputs driven 1ns after posedge, outputs sampled there too.
// Backpressure: bench drives out_ready_i explicitly per step.
module tb_commit_trace_buffer;
  localparam int XLEN  = riscv_pkg::XLEN;
  localparam int RET_W = 2;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clk, rstn;
  logic [RET_W-1:0]      ret_valid, ret_stall;
  logic [RET_W*XLEN-1:0] ret_pc, ret_instr, ret_rd_data;
  logic [RET_W*5-1:0]    ret_rd;
  logic                  trace_en, filter_stall, wrap_mode, flush, out_ready;
  logic                  out_valid, out_stall;
  logic [XLEN-1:0]       out_pc, out_instr, out_rd_data;
  logic [4:0]            out_rd;
  logic [CW-1:0]         count;
  logic [CNT_W-1:0]      drop_cnt;
  logic                  overflow;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [31:0]           out_ts;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  commit_trace_buffer #(.RET_W(RET_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .ret_valid_i    (ret_valid),
    .ret_pc_i       (ret_pc),
    .ret_instr_i    (ret_instr),
    .ret_rd_i       (ret_rd),
    .ret_rd_data_i  (ret_rd_data),
    .ret_stall_i    (ret_stall),
    .trace_en_i     (trace_en),
    .filter_stall_i (filter_stall),
    .wrap_mode_i    (wrap_mode),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_instr_o    (out_instr),
    .out_rd_o       (out_rd),
    .out_rd_data_o  (out_rd_data),
    .out_stall_o    (out_stall),
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    .out_ts_o       (out_ts),
`endif
    .count_o        (count),
    .drop_cnt_o     (drop_cnt),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ret_valid   = '0;
    ret_stall   = '0;
    ret_pc      = '0;
    ret_instr   = '0;
    ret_rd      = '0;
    ret_rd_data = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] data, input logic stall);
    ret_valid[k]             = 1'b1;
    ret_pc[k*XLEN +: XLEN]    = pc;
    ret_instr[k*XLEN +: XLEN] = pc ^ 32'h13;
    ret_rd[k*5 +: 5]          = rd;
    ret_rd_data[k*XLEN +: XLEN] = data;
    ret_stall[k]              = stall;
  endtask

  task automatic push1(input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] data, input logic stall);
    idle();
    set_lane(0, pc, rd, data, stall);
    tick();
    idle();
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_pc"}, 64'(out_pc), 64'(exp_q.pop_front()));
      pop1();
    end
    check({tag, "_empty"}, 64'(count), 64'd0);
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    trace_en     = 1'b1;
    filter_stall = 1'b0;
    wrap_mode    = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rstn = 1'b1;

    // First entry: not visible before its write edge, visible after it.
    idle();
    set_lane(0, 32'h0, 5'd5, 32'h11, 1'b0);
    check("nobypass_valid", 64'(out_valid), 64'd0);
    tick();
    idle();
    check("lat_valid", 64'(out_valid), 64'd1);
    push1(32'h4, 5'd5, 32'h11, 1'b0);
    push1(32'h8, 5'd5, 32'h11, 1'b0);
    check("t1_count", 64'(count), 64'd3);
    check("t1_pc", 64'(out_pc), 64'h0);
    check("t1_instr", 64'(out_instr), 64'h13);
    check("t1_rd", 64'(out_rd), 64'd5);
    check("t1_data", 64'(out_rd_data), 64'h11);

    // Asynchronous reset in the middle of a burst.
    set_lane(0, 32'hC, 5'd5, 32'h11, 1'b0);
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_pc", 64'(out_pc), 64'd0);
    check("midrst_rd", 64'(out_rd), 64'd0);
    idle();
    #1;
    rstn = 1'b1;
    tick();

    // Stop mode: 18 retires into 16 entries, newest two dropped.
    wrap_mode = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push1(32'(i * 4), 5'd1, 32'(i), 1'b0);
      if (i < 16) exp_q.push_back(32'(i * 4));
    end
    check("stop_count", 64'(count), 64'd16);
    check("stop_drop", 64'(drop_cnt), 64'd2);
    check("stop_ovf", 64'(overflow), 64'd1);
    drain_check("stop_drain");
    do_flush();

    // Wrap mode: same stimulus, the two oldest are overwritten.
    wrap_mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      push1(32'(i * 4), 5'd1, 32'(i), 1'b0);
      if (i >= 2) exp_q.push_back(32'(i * 4));
    end
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_drop", 64'(drop_cnt), 64'd2);
    check("wrap_ovf", 64'(overflow), 64'd1);
    check("wrap_head", 64'(out_pc), 64'h8);
    drain_check("wrap_drain");
    do_flush();

    // Two lanes against one free slot, then with a same-cycle pop.
    wrap_mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push1(32'h100 + 32'(i * 4), 5'd1, 32'(i), 1'b0);
      exp_q.push_back(32'h100 + 32'(i * 4));
    end
    check("dual_fill", 64'(count), 64'd15);
    idle();
    set_lane(0, 32'h200, 5'd2, 32'h1, 1'b0);
    set_lane(1, 32'h204, 5'd2, 32'h2, 1'b0);
    tick();
    idle();
    exp_q.push_back(32'h200);
    check("dual_nopop_count", 64'(count), 64'd16);
    check("dual_nopop_drop", 64'(drop_cnt), 64'd1);
    check("dual_nopop_ovf", 64'(overflow), 64'd1);
    check("dual_pop_head", 64'(out_pc), 64'(exp_q.pop_front()));
    pop1();
    check("dual_15", 64'(count), 64'd15);
    check("dual_pop2_head", 64'(out_pc), 64'(exp_q.pop_front()));
    set_lane(0, 32'h300, 5'd2, 32'h3, 1'b0);
    set_lane(1, 32'h304, 5'd2, 32'h4, 1'b0);
    out_ready = 1'b1;
    tick();
    idle();
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h304);
    check("dual_pop_count", 64'(count), 64'd16);
    check("dual_pop_drop", 64'(drop_cnt), 64'd1);
    drain_check("dual_drain");
    do_flush();

    // Stall filtering, rd=0 data masking, lane packing, capture disable.
    filter_stall = 1'b1;
    push1(32'h400, 5'd3, 32'hAA, 1'b0);
    push1(32'h404, 5'd4, 32'hCC, 1'b1);
    push1(32'h408, 5'd0, 32'hBB, 1'b0);
    push1(32'h40C, 5'd6, 32'hDD, 1'b1);
    check("filt_count", 64'(count), 64'd2);
    check("filt_drop", 64'(drop_cnt), 64'd0);
    check("filt_ovf", 64'(overflow), 64'd0);
    check("filt_pc0", 64'(out_pc), 64'h400);
    check("filt_data0", 64'(out_rd_data), 64'hAA);
    pop1();
    check("filt_pc1", 64'(out_pc), 64'h408);
    check("rd0_rd", 64'(out_rd), 64'd0);
    check("rd0_data", 64'(out_rd_data), 64'd0);
    pop1();
    idle();
    set_lane(0, 32'h500, 5'd7, 32'h1, 1'b1);
    set_lane(1, 32'h504, 5'd7, 32'h2, 1'b0);
    tick();
    idle();
    check("pack_count", 64'(count), 64'd1);
    check("pack_pc", 64'(out_pc), 64'h504);
    trace_en = 1'b0;
    pop1();
    push1(32'h600, 5'd1, 32'h1, 1'b0);
    check("en_off_count", 64'(count), 64'd0);
    trace_en     = 1'b1;
    filter_stall = 1'b0;
    push1(32'h700, 5'd1, 32'h1, 1'b1);
    check("stall_flag", 64'(out_stall), 64'd1);
    pop1();

    // Flush beats simultaneous push and pop.
    wrap_mode = 1'b1;
    for (int i = 0; i < 17; i++) push1(32'h800 + 32'(i * 4), 5'd1, 32'(i), 1'b0);
    check("preflush_drop", 64'(drop_cnt), 64'd1);
    idle();
    set_lane(0, 32'h900, 5'd1, 32'h1, 1'b0);
    set_lane(1, 32'h904, 5'd1, 32'h2, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    idle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_drop", 64'(drop_cnt), 64'd0);
    check("flush_ovf", 64'(overflow), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);

    // First cycle after flush: both lanes share timestamp 0, next cycle gets 1.
    set_lane(0, 32'hA00, 5'd1, 32'h1, 1'b0);
    set_lane(1, 32'hA04, 5'd1, 32'h2, 1'b0);
    tick();
    push1(32'hA08, 5'd1, 32'h3, 1'b0);
    check("ts_pc0", 64'(out_pc), 64'hA00);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    check("ts_lane0", 64'(out_ts), 64'd0);
`endif
    pop1();
    check("ts_pc1", 64'(out_pc), 64'hA04);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    check("ts_lane1", 64'(out_ts), 64'd0);
`endif
    pop1();
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    check("ts_next", 64'(out_ts), 64'd1);
`endif
    pop1();
    do_flush();

    // Drop counter saturation: 8 cycles fill, then 2 drops per cycle.
    wrap_mode = 1'b0;
    set_lane(0, 32'hB00, 5'd1, 32'h1, 1'b0);
    set_lane(1, 32'hB04, 5'd1, 32'h2, 1'b0);
    repeat (8 + 32767) tick();
    check("sat_pre", 64'(drop_cnt), 64'hFFFE);
    tick();
    check("sat_hit", 64'(drop_cnt), 64'hFFFF);
    tick();
    check("sat_hold", 64'(drop_cnt), 64'hFFFF);
    check("sat_count", 64'(count), 64'd16);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
